// File: rtl/apb_master_bridge.sv
// APB master bridge: turns valid/ready commands into APB transfers
// and returns each completion, slave error or timeout as a held response.
//
// Ports
//   pclk, rst_n                       clock, async active-low reset
//   req_valid/req_ready               command handshake (ready only in IDLE)
//   req_write, req_addr, req_wdata    command payload
//   rsp_valid/rsp_ready               response handshake (valid only in RESP)
//   rsp_rdata, rsp_err, rsp_timeout   response payload
//   psel, penable, pwrite, paddr,
//   pwdata, prdata, pready, pslverr   APB master side
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] wait_inc;
   logic       init_done;
   logic       accept;
   logic       acc_done;
   logic       acc_abort;

   // req_ready stays low through reset and comes up on the first
   // edge after release, so a command can never land on that edge.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b1;
      end
   end

   assign req_ready = init_done && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign wait_inc  = wait_cnt + 8'd1;

   // pready wins over the timeout on the edge the limit would be hit.
   assign acc_done  = (state == ACCESS) && pready;
   assign acc_abort = (state == ACCESS) && !pready && (wait_inc == TO_LIM);

   assign psel      = (state == SETUP) || (state == ACCESS);
   assign penable   = (state == ACCESS);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (acc_done || acc_abort) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Wait-state counter: cleared as SETUP is entered, counts
   // ACCESS cycles in which the slave holds pready low.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= 8'd0;
      end else if (accept) begin
         wait_cnt <= 8'd0;
      end else if ((state == ACCESS) && !pready) begin
         wait_cnt <= wait_inc;
      end
   end

   // Command fields are held from acceptance until the next command,
   // so they remain stable through SETUP/ACCESS and linger afterwards.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         pwrite <= 1'b0;
         paddr  <= '0;
         pwdata <= '0;
      end else if (accept) begin
         pwrite <= req_write;
         paddr  <= req_addr;
         pwdata <= req_wdata;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else if (acc_done) begin
         rsp_rdata   <= pwrite ? '0 : prdata;
         rsp_err     <= pslverr;
         rsp_timeout <= 1'b0;
      end else if (acc_abort) begin
         rsp_rdata   <= '0;
         rsp_err     <= 1'b1;
         rsp_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: a transaction-level model
// predicts every APB/response signal per cycle under random traffic.
module tb_apb_master_bridge;

   localparam int TO = 16;

   logic        pclk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   apb_master_bridge #(
      .ADDR_W (32),
      .DATA_W (32),
      .TIMEOUT(TO)
   ) dut (
      .pclk       (pclk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   // expected per-cycle outputs
   logic        e_rdy, e_psel, e_pen, e_rv;
   logic        e_pwrite;
   logic [31:0] e_paddr, e_pwdata, e_rd;
   logic        e_err, e_to;

   // monitor observations
   int          cyc = 0;
   int          cnt_psel = 0;
   int          cnt_pen = 0;
   int          cnt_rv = 0;
   int          rise_cyc = 0;
   logic        prev_rv = 1'b0;
   logic [31:0] rise_rd = '0;
   logic        rise_err = 1'b0;
   logic        rise_to = 1'b0;

   // per-transaction observations
   int          acc_c;
   int          o_psel, o_pen, o_rv, o_lat;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp,
                  $time);
      end
   endtask

   always @(posedge pclk) cyc <= cyc + 1;

   always @(negedge pclk) begin
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("psel", 64'(psel), 64'(e_psel));
      chk("penable", 64'(penable), 64'(e_pen));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("pwrite", 64'(pwrite), 64'(e_pwrite));
      chk("paddr", 64'(paddr), 64'(e_paddr));
      chk("pwdata", 64'(pwdata), 64'(e_pwdata));
      if (e_rv) begin
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
         chk("rsp_err", 64'(rsp_err), 64'(e_err));
         chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
      end
      cnt_psel += int'(psel);
      cnt_pen  += int'(penable);
      cnt_rv   += int'(rsp_valid);
      if (rsp_valid && !prev_rv) begin
         rise_cyc = cyc;
         rise_rd  = rsp_rdata;
         rise_err = rsp_err;
         rise_to  = rsp_timeout;
      end
      prev_rv = rsp_valid;
   end

   task automatic set_reset_exp();
      e_rdy = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
      e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
      e_rd = '0; e_err = 1'b0; e_to = 1'b0;
   endtask

   task automatic slave_noise();
      pready  = 1'($urandom);
      pslverr = 1'($urandom);
      prdata  = $urandom;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 1'b0;
         rsp_ready = 1'($urandom);
         slave_noise();
         @(posedge pclk); #1;
      end
   endtask

   // One command from IDLE to IDLE. The slave answers after 'waits'
   // low-pready ACCESS cycles; the response is held for 'bp' cycles.
   task automatic run_txn(input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int waits,
                          input logic serr, input logic [31:0] rd,
                          input int bp);
      logic to;
      int   nacc;
      int   b_psel, b_pen, b_rv;
      to   = (waits >= TO);
      nacc = to ? TO : waits + 1;
      b_psel = cnt_psel; b_pen = cnt_pen; b_rv = cnt_rv;
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      rsp_ready = 1'($urandom);
      slave_noise();
      acc_c = cyc;
      @(posedge pclk); #1;
      // SETUP
      e_rdy = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
      e_pwrite = wr; e_paddr = a; e_pwdata = d;
      req_valid = 1'($urandom); req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      slave_noise();
      @(posedge pclk); #1;
      // ACCESS
      for (int i = 0; i < nacc; i++) begin
         e_pen = 1'b1;
         req_valid = 1'($urandom);
         if (!to && i == waits) begin
            pready = 1'b1; pslverr = serr; prdata = rd;
         end else begin
            pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
         end
         @(posedge pclk); #1;
      end
      // RESP
      e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b1;
      e_rd  = (to || wr) ? 32'd0 : rd;
      e_err = to ? 1'b1 : serr;
      e_to  = to;
      for (int k = 0; k <= bp; k++) begin
         rsp_ready = (k == bp);
         req_valid = 1'($urandom);
         slave_noise();
         @(posedge pclk); #1;
      end
      // back in IDLE
      e_rv = 1'b0; e_rdy = 1'b1;
      req_valid = 1'b0;
      o_psel = cnt_psel - b_psel;
      o_pen  = cnt_pen - b_pen;
      o_rv   = cnt_rv - b_rv;
      o_lat  = rise_cyc - acc_c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
      set_reset_exp();
      #2;
      chk("rst psel", 64'(psel), 64'd0);
      chk("rst penable", 64'(penable), 64'd0);
      chk("rst pwrite", 64'(pwrite), 64'd0);
      chk("rst paddr", 64'(paddr), 64'd0);
      chk("rst pwdata", 64'(pwdata), 64'd0);
      chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst rsp_err", 64'(rsp_err), 64'd0);
      chk("rst rsp_timeout", 64'(rsp_timeout), 64'd0);
      chk("rst req_ready", 64'(req_ready), 64'd0);
      #11;
      rst_n = 1'b1;
      #1;
      chk("req_ready pre-edge", 64'(req_ready), 64'd0);
      @(posedge pclk); #1;
      e_rdy = 1'b1;
      chk("req_ready post-edge", 64'(req_ready), 64'd1);

      // zero-wait write
      run_txn(1'b1, 32'h8, 32'hface_5678, 0, 1'b0, 32'h1111_2222, 0);
      chk("zw psel cycles", 64'(o_psel), 64'd2);
      chk("zw penable cycles", 64'(o_pen), 64'd1);
      chk("zw latency", 64'(o_lat), 64'd3);
      chk("zw err", 64'(rise_err), 64'd0);
      chk("zw rdata", 64'(rise_rd), 64'd0);

      // wait-state read
      run_txn(1'b0, 32'h4, 32'h0, 3, 1'b0, 32'hcafe_1234, 0);
      chk("ws penable cycles", 64'(o_pen), 64'd4);
      chk("ws rdata", 64'(rise_rd), 64'hcafe_1234);
      chk("ws latency", 64'(o_lat), 64'd6);

      // slave error
      idle_cycles(1);
      run_txn(1'b0, 32'hffff_ffff, 32'h5, 0, 1'b1, 32'h77, 0);
      chk("se err", 64'(rise_err), 64'd1);
      chk("se timeout", 64'(rise_to), 64'd0);

      // timeout
      run_txn(1'b0, 32'h10, 32'h0, 40, 1'b0, 32'h99, 0);
      chk("to penable cycles", 64'(o_pen), 64'd16);
      chk("to err", 64'(rise_err), 64'd1);
      chk("to timeout", 64'(rise_to), 64'd1);
      chk("to rdata", 64'(rise_rd), 64'd0);

      // pready on the edge the limit is reached
      run_txn(1'b0, 32'h20, 32'h0, TO - 1, 1'b0, 32'habcd_0001, 0);
      chk("edge penable cycles", 64'(o_pen), 64'd16);
      chk("edge timeout", 64'(rise_to), 64'd0);
      chk("edge rdata", 64'(rise_rd), 64'habcd_0001);

      // backpressure
      run_txn(1'b1, 32'h30, 32'h1234_5678, 0, 1'b0, 32'h0, 5);
      chk("bp rsp_valid cycles", 64'(o_rv), 64'd6);

      // reset during ACCESS wait state
      req_valid = 1'b1; req_write = 1'b0;
      req_addr = 32'h44; req_wdata = 32'h55;
      pready = 1'b0;
      @(posedge pclk); #1;
      req_valid = 1'b0;
      e_rdy = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
      e_pwrite = 1'b0; e_paddr = 32'h44; e_pwdata = 32'h55;
      @(posedge pclk); #1;
      e_pen = 1'b1;
      pready = 1'b0;
      @(posedge pclk); #1;
      #2;
      rst_n = 1'b0;
      set_reset_exp();
      #1;
      chk("mid rst psel", 64'(psel), 64'd0);
      chk("mid rst penable", 64'(penable), 64'd0);
      chk("mid rst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid rst paddr", 64'(paddr), 64'd0);
      @(posedge pclk); #3;
      rst_n = 1'b1;
      @(posedge pclk); #1;
      e_rdy = 1'b1;
      idle_cycles(1);
      run_txn(1'b0, 32'h48, 32'h0, 1, 1'b0, 32'h600d_f00d, 0);
      chk("post rst rdata", 64'(rise_rd), 64'h600d_f00d);
      chk("post rst err", 64'(rise_err), 64'd0);
      chk("post rst latency", 64'(o_lat), 64'd4);

      // random traffic
      for (int t = 0; t < 40; t++) begin
         int w;
         if ($urandom_range(0, 7) == 0) w = $urandom_range(TO - 1, TO + 2);
         else w = $urandom_range(0, 4);
         run_txn(1'($urandom), $urandom, $urandom, w, 1'($urandom),
                 $urandom, $urandom_range(0, 3));
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
